// File: rtl/core_collect_pkg.sv
// rtl/core_collect_pkg.sv - shared types and widths for the core result collector
//
// Purpose: state encoding, data/index widths and the FIFO entry layout used
//          by core_result_collector and its result_fifo instance.
// Ports:   none (package).
package core_collect_pkg;

  localparam int DATA_W     = 32;
  localparam int CORE_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [CORE_IDX_W-1:0] core;
    logic [DATA_W-1:0]     val_1;
    logic [DATA_W-1:0]     val_2;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - synchronous show-ahead FIFO with full/empty flags
//
// Purpose: small circular-buffer FIFO; the head entry is visible on head_data
//          whenever empty is 0, and pop retires it on the next clock edge.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push         write push_data (ignored while full)
//   push_data    entry to store
//   pop          retire the head entry (ignored while empty)
//   head_data    current head entry (show-ahead)
//   full, empty  occupancy flags, both from the registered count
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the start-of-cycle count, so a pop never makes room
  // for a push in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_result_collector.sv
// rtl/core_result_collector.sv - round-robin collector of child core results
//
// Purpose: scans child core done flags round-robin, captures each finished
//          core once per round into a result FIFO and presents the entries
//          to the parent core on a valid/ready port.
// Optional feature macro: COLLECT_MIN_EN adds best_val/best_core, tracking
//          the smallest val_1 captured this round (earliest wins on ties).
// Ports:
//   Clk, Reset             clock, asynchronous active-high reset
//   start                  begin a round (honoured in IDLE or DONE only)
//   core_flag              per-core done flags
//   core_val_1/core_val_2  flattened per-core values, core i at [32i+31:32i]
//   res_valid/res_ready    result handshake, pop when both are 1
//   res_core, res_val_1/2  head entry (zero while res_valid is 0)
//   collected              cores captured this round
//   busy                   scanning or draining
//   all_done               round complete and FIFO drained
//   best_val, best_core    minimum tracker outputs (COLLECT_MIN_EN only)
module core_result_collector
  import core_collect_pkg::*;
#(
  parameter int NUM_CORES  = 31,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        core_flag,
  input  logic [DATA_W*NUM_CORES-1:0] core_val_1,
  input  logic [DATA_W*NUM_CORES-1:0] core_val_2,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [CORE_IDX_W-1:0]       res_core,
  output logic [DATA_W-1:0]           res_val_1,
  output logic [DATA_W-1:0]           res_val_2,
  output logic [NUM_CORES-1:0]        collected,
  output logic                        busy,
  output logic                        all_done
`ifdef COLLECT_MIN_EN
  ,
  output logic [DATA_W-1:0]           best_val,
  output logic [CORE_IDX_W-1:0]       best_core
`endif
);

  state_t                state_q, state_d;
  logic [CORE_IDX_W-1:0] ptr_q, ptr_d;
  logic [NUM_CORES-1:0]  collected_q, collected_d;
  logic                  push;
  logic                  clear_round;
  logic                  eligible;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [CORE_IDX_W-1:0] ptr_next;
  entry_t                push_entry;
  entry_t                head_entry;

  logic [DATA_W-1:0] v1_arr [NUM_CORES];
  logic [DATA_W-1:0] v2_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign v1_arr[g] = core_val_1[DATA_W*g +: DATA_W];
    assign v2_arr[g] = core_val_2[DATA_W*g +: DATA_W];
  end

  assign eligible = core_flag[ptr_q] & ~collected_q[ptr_q];
  assign ptr_next = (ptr_q == CORE_IDX_W'(NUM_CORES - 1)) ? '0 : ptr_q + 1'b1;

  assign push_entry.core  = ptr_q;
  assign push_entry.val_1 = v1_arr[ptr_q];
  assign push_entry.val_2 = v2_arr[ptr_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    collected_d = collected_q;
    push        = 1'b0;
    clear_round = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_round = 1'b1;
          ptr_d       = '0;
          collected_d = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // An eligible core facing a full FIFO holds the pointer so it is
        // not skipped for a whole lap.
        if (!(eligible && fifo_full)) begin
          if (eligible) begin
            push                = 1'b1;
            collected_d[ptr_q]  = 1'b1;
          end
          ptr_d = ptr_next;
        end
        if (&collected_d) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      collected_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      collected_q <= collected_d;
    end
  end

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign pop       = res_valid & res_ready;

  // FIFO storage is not reset, so the head is masked while nothing is queued.
  assign res_core  = fifo_empty ? '0 : head_entry.core;
  assign res_val_1 = fifo_empty ? '0 : head_entry.val_1;
  assign res_val_2 = fifo_empty ? '0 : head_entry.val_2;

  assign collected = collected_q;
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign all_done  = (state_q == ST_DONE);

`ifdef COLLECT_MIN_EN
  // An empty collected mask marks the first push of the round, which seeds
  // the tracker regardless of the reset value. Strict less-than keeps the
  // earlier capture on ties.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      best_val  <= '1;
      best_core <= '0;
    end else if (clear_round) begin
      best_val  <= '1;
      best_core <= '0;
    end else if (push && ((~|collected_q) || (push_entry.val_1 < best_val))) begin
      best_val  <= push_entry.val_1;
      best_core <= ptr_q;
    end
  end
`endif

endmodule

// File: tb/tb_core_result_collector.sv
// tb/tb_core_result_collector.sv - scoreboard bench for core_result_collector
module tb_core_result_collector;

  localparam int NUM = 31;

  logic              Clk;
  logic              Reset;
  logic              start;
  logic [NUM-1:0]    core_flag;
  logic [32*NUM-1:0] core_val_1;
  logic [32*NUM-1:0] core_val_2;
  logic              res_valid;
  logic              res_ready;
  logic [4:0]        res_core;
  logic [31:0]       res_val_1;
  logic [31:0]       res_val_2;
  logic [NUM-1:0]    collected;
  logic              busy;
  logic              all_done;
`ifdef COLLECT_MIN_EN
  logic [31:0]       best_val;
  logic [4:0]        best_core;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  core;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  exp_t exp_q[$];

  core_result_collector #(.NUM_CORES(NUM), .FIFO_DEPTH(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .core_flag  (core_flag),
    .core_val_1 (core_val_1),
    .core_val_2 (core_val_2),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_core   (res_core),
    .res_val_1  (res_val_1),
    .res_val_2  (res_val_2),
    .collected  (collected),
    .busy       (busy),
    .all_done   (all_done)
`ifdef COLLECT_MIN_EN
    ,
    .best_val   (best_val),
    .best_core  (best_core)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] v1f(int i);
    if (i == 12 || i == 20) return 32'd3;
    return 32'(100 - i);
  endfunction

  function automatic logic [31:0] v2f(int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_core(input int i);
    exp_t e;
    e.core = 5'(i);
    e.v1   = v1f(i);
    e.v2   = v2f(i);
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!all_done && n < bound) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (!all_done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: timeout after %0d cycles, all_done=%0b", n, all_done);
    end
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    #1;
    exp_q.delete();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // Monitor: every handshake pops the scoreboard.
  always @(negedge Clk) begin
    if (!Reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got core %0d, expected no entry", res_core);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_core", 64'(res_core), 64'(e.core));
        chk("pop_val_1", 64'(res_val_1), 64'(e.v1));
        chk("pop_val_2", 64'(res_val_2), 64'(e.v2));
      end
    end
  end

  initial begin
    int n;
    Reset     = 1'b1;
    start     = 1'b0;
    core_flag = '0;
    res_ready = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      core_val_1[32*i +: 32] = v1f(i);
      core_val_2[32*i +: 32] = v2f(i);
    end
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_core", 64'(res_core), 64'd0);
    chk("rst_res_val_1", 64'(res_val_1), 64'd0);
    chk("rst_res_val_2", 64'(res_val_2), 64'd0);
    chk("rst_collected", 64'(collected), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_all_done", 64'(all_done), 64'd0);
`ifdef COLLECT_MIN_EN
    chk("rst_best_val", 64'(best_val), 64'hFFFF_FFFF);
    chk("rst_best_core", 64'(best_core), 64'd0);
`endif
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // All flags high, parent always ready: cores 0..30 in order, done at 33.
    core_flag = '1;
    res_ready = 1'b1;
    for (int i = 0; i < NUM; i++) expect_core(i);
    do_start();
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done(100, n);
    chk("t1_done_cycles", 64'(n), 64'd33);
    chk("t1_collected", 64'(collected), 64'h7FFF_FFFF);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef COLLECT_MIN_EN
    chk("t1_best_val", 64'(best_val), 64'd3);
    chk("t1_best_core", 64'(best_core), 64'd12);
`endif

    // Parent stalled: FIFO fills with cores 0-3 and the pointer holds at 4.
    res_ready = 1'b0;
    for (int i = 0; i < NUM; i++) expect_core(i);
    do_start();
    repeat (10) @(posedge Clk);
    #1;
    chk("t2_collected_stall", 64'(collected), 64'hF);
    chk("t2_res_valid", 64'(res_valid), 64'd1);
    chk("t2_head_core", 64'(res_core), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    res_ready = 1'b1;
    wait_done(200, n);
    chk("t2_collected", 64'(collected), 64'h7FFF_FFFF);
    chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Core 17 first, core 5 raised 10 cycles later: order 17 then 5.
    core_flag = NUM'(1) << 17;
    expect_core(17);
    expect_core(5);
    do_start();
    repeat (10) @(posedge Clk);
    #1;
    core_flag[5] = 1'b1;
    repeat (60) @(posedge Clk);
    #1;
    chk("t3_collected", 64'(collected), 64'h0002_0020);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_all_done", 64'(all_done), 64'd0);
    chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    pulse_reset();

    // Core 9 flag pulses for exactly the cycle the pointer sits on it.
    core_flag = '0;
    expect_core(9);
    do_start();
    repeat (9) @(posedge Clk);
    #1;
    core_flag[9] = 1'b1;
    @(posedge Clk);
    #1;
    core_flag[9] = 1'b0;
    repeat (40) @(posedge Clk);
    #1;
    chk("t4_collected_once", 64'(collected), 64'h200);
    core_flag[9] = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    core_flag[9] = 1'b0;
    chk("t4_collected_rerise", 64'(collected), 64'h200);
    chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("t4_res_valid", 64'(res_valid), 64'd0);
    pulse_reset();

    // Reset mid-scan with two entries queued aborts the round.
    res_ready = 1'b0;
    core_flag = NUM'(3);
    expect_core(0);
    expect_core(1);
    do_start();
    repeat (5) @(posedge Clk);
    #1;
    chk("t5_collected_pre", 64'(collected), 64'h3);
    chk("t5_res_valid_pre", 64'(res_valid), 64'd1);
    Reset = 1'b1;
    #1;
    chk("t5_res_valid", 64'(res_valid), 64'd0);
    chk("t5_collected", 64'(collected), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_all_done", 64'(all_done), 64'd0);
    exp_q.delete();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("t5_idle_busy", 64'(busy), 64'd0);
    chk("t5_idle_valid", 64'(res_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
